// File: rtl/wbr_shift_master.sv
// rtl/wbr_shift_master.sv - IEEE 1500 WBR capture/shift/update serial master.
// Optional compare logic (expected_in, mask_in, mismatch) is enabled by WBR_COMPARE_EN.
module wbr_shift_master #(
  parameter int WBR_LEN = 8,
  parameter int CNT_W   = $clog2(WBR_LEN + 1)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               capture_en,
  input  logic [WBR_LEN-1:0] pattern_in,
`ifdef WBR_COMPARE_EN
  input  logic [WBR_LEN-1:0] expected_in,
  input  logic [WBR_LEN-1:0] mask_in,
  output logic               mismatch,
`endif
  input  logic               WPSO0,
  output logic               WPSI0,
  output logic               wse_outputs,
  output logic               hold_outputs,
  output logic               capture_wr,
  output logic               update_wr,
  output logic               busy,
  output logic               done,
  output logic [WBR_LEN-1:0] result_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WBR_LEN-1:0] pat_q;
  logic [WBR_LEN-1:0] res_q;

`ifdef WBR_COMPARE_EN
  logic [WBR_LEN-1:0] exp_q;
  logic [WBR_LEN-1:0] mask_q;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pat_q <= '0;
      res_q <= '0;
`ifdef WBR_COMPARE_EN
      exp_q    <= '0;
      mask_q   <= '0;
      mismatch <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q <= pattern_in;
            cnt   <= CNT_W'(WBR_LEN - 1);
`ifdef WBR_COMPARE_EN
            exp_q    <= expected_in;
            mask_q   <= mask_in;
            mismatch <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // Response enters at the MSB so the first bit received ends in bit 0.
          pat_q <= pat_q >> 1;
          res_q <= {WPSO0, res_q[WBR_LEN-1:1]};
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        UPDATE: begin
`ifdef WBR_COMPARE_EN
          mismatch <= |((res_q ^ exp_q) & mask_q);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    WPSI0        = 1'b0;
    wse_outputs  = 1'b0;
    hold_outputs = 1'b0;
    capture_wr   = 1'b0;
    update_wr    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = capture_en ? CAPTURE : SHIFT;
        end
      end
      CAPTURE: begin
        capture_wr   = 1'b1;
        hold_outputs = 1'b1;
        busy         = 1'b1;
        state_next   = SHIFT;
      end
      SHIFT: begin
        WPSI0        = pat_q[0];
        wse_outputs  = 1'b1;
        hold_outputs = 1'b1;
        busy         = 1'b1;
        if (cnt == '0) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        update_wr    = 1'b1;
        hold_outputs = 1'b1;
        busy         = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign result_out = res_q;

endmodule

// File: tb/tb_wbr_shift_master.sv
// tb/tb_wbr_shift_master.sv - randomized bench for wbr_shift_master with a timeline reference model.
// Drives an 8-cell WBR behavioural model; compare checks run when WBR_COMPARE_EN is defined.
module tb_wbr_shift_master;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         capture_en = 1'b0;
  logic [W-1:0] pattern_in = '0;
  logic         WPSO0;
  logic         WPSI0, wse_outputs, hold_outputs, capture_wr, update_wr, busy, done;
  logic [W-1:0] result_out;
`ifdef WBR_COMPARE_EN
  logic [W-1:0] expected_in = '0;
  logic [W-1:0] mask_in = '0;
  logic         mismatch;
`endif

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  wbr_shift_master #(.WBR_LEN(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .capture_en(capture_en), .pattern_in(pattern_in),
`ifdef WBR_COMPARE_EN
    .expected_in(expected_in), .mask_in(mask_in), .mismatch(mismatch),
`endif
    .WPSO0(WPSO0), .WPSI0(WPSI0), .wse_outputs(wse_outputs), .hold_outputs(hold_outputs),
    .capture_wr(capture_wr), .update_wr(update_wr), .busy(busy), .done(done),
    .result_out(result_out)
  );

  // WBR chain model: capture loads capval, shift moves toward cell 0, update copies the chain.
  logic [W-1:0] chain = '0;
  logic [W-1:0] upd = '0;
  logic [W-1:0] capval = 8'h3C;
  logic [W-1:0] chain_load_val = '0;
  logic         chain_load = 1'b0;
  logic         loopback = 1'b0;

  assign WPSO0 = loopback ? WPSI0 : chain[0];

  always @(posedge CLK) begin
    if (chain_load) chain <= chain_load_val;
    else if (capture_wr) chain <= capval;
    else if (wse_outputs) chain <= {WPSI0, chain[W-1:1]};
    if (update_wr) upd <= chain;
  end

  int n_cap = 0, n_wse = 0, n_upd = 0, n_done = 0;
  always @(posedge CLK) begin
    n_cap  <= n_cap + int'(capture_wr);
    n_wse  <= n_wse + int'(wse_outputs);
    n_upd  <= n_upd + int'(update_wr);
    n_done <= n_done + int'(done);
  end

  // Reference: operation timeline by cycle index since the accepting edge (1 = first busy cycle).
  logic         m_act = 1'b0;
  int           m_c = 0;
  logic         m_cap = 1'b0;
  logic [W-1:0] m_pat = '0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] res_hold = '0;
  logic         m_mis = 1'b0;
  logic [W-1:0] m_exp = '0;
  logic [W-1:0] m_mask = '0;

  always @(posedge CLK) begin
    if (reset) begin
      m_act    <= 1'b0;
      m_c      <= 0;
      res_hold <= '0;
      m_mis    <= 1'b0;
    end else if (m_act) begin
      if (m_c == W + 2 + int'(m_cap)) begin
        m_act    <= 1'b0;
        m_c      <= 0;
        res_hold <= m_res;
        m_mis    <= |((m_res ^ m_exp) & m_mask);
      end else begin
        m_c <= m_c + 1;
      end
    end else if (start) begin
      m_act <= 1'b1;
      m_c   <= 1;
      m_cap <= capture_en;
      m_pat <= pattern_in;
      m_res <= loopback ? pattern_in : (capture_en ? capval : chain);
      m_mis <= 1'b0;
`ifdef WBR_COMPARE_EN
      m_exp  <= expected_in;
      m_mask <= mask_in;
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int   s0, s1, dn;
  logic e_cap, e_wse, e_upd, e_done, e_busy, e_psi;

  always @(negedge CLK) begin
    s0     = 1 + int'(m_cap);
    s1     = W + int'(m_cap);
    dn     = W + 2 + int'(m_cap);
    e_cap  = m_act && m_cap && m_c == 1;
    e_wse  = m_act && m_c >= s0 && m_c <= s1;
    e_upd  = m_act && m_c == W + 1 + int'(m_cap);
    e_done = m_act && m_c == dn;
    e_busy = m_act && m_c >= 1 && m_c < dn;
    e_psi  = e_wse ? m_pat[m_c - s0] : 1'b0;
    chk("capture_wr", capture_wr, e_cap);
    chk("wse_outputs", wse_outputs, e_wse);
    chk("update_wr", update_wr, e_upd);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("hold_outputs", hold_outputs, e_busy);
    chk("WPSI0", WPSI0, e_psi);
    if (!m_act || m_c <= s0) chk("result_hold", result_out, res_hold);
    if (e_done) begin
      chk("result_done", result_out, m_res);
      chk("wbr_update", upd, m_pat);
    end
`ifdef WBR_COMPARE_EN
    if (e_done) chk("mismatch_done", mismatch, |((m_res ^ m_exp) & m_mask));
    else chk("mismatch", mismatch, m_mis);
`endif
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_chain(input logic [W-1:0] v);
    chain_load = 1'b1;
    chain_load_val = v;
    step();
    chain_load = 1'b0;
  endtask

  // Issues one start, waits for done (bounded); spam pulses start while busy and in the DONE cycle.
  task automatic run_op(input logic [W-1:0] pat, input logic cap, input bit spam, output int lat);
    start = 1'b1;
    pattern_in = pat;
    capture_en = cap;
    step();
    start = 1'b0;
    pattern_in = W'($urandom);
    capture_en = 1'($urandom);
`ifdef WBR_COMPARE_EN
    expected_in = W'($urandom);
    mask_in = W'($urandom);
`endif
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (spam) start = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    start = 1'b0;
    if (lat >= 40) chk("done_timeout", done, 1);
    if (spam) start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int lat, c_cap, c_wse, c_upd, c_done, k;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("reset_result", result_out, 0);
    chk("reset_busy", busy, 0);
    load_chain(8'h00);

    c_cap = n_cap; c_wse = n_wse; c_upd = n_upd; c_done = n_done;
    capval = 8'h3C;
    run_op(8'hA5, 1'b1, 1'b0, lat);
    chk("full_result", result_out, 8'h3C);
    chk("full_update", upd, 8'hA5);
    chk("full_latency", lat, 11);
    chk("full_cap_cnt", n_cap - c_cap, 1);
    chk("full_wse_cnt", n_wse - c_wse, 8);
    chk("full_upd_cnt", n_upd - c_upd, 1);
    chk("full_done_cnt", n_done - c_done, 1);

    load_chain(8'hF0);
    c_cap = n_cap;
    run_op(8'h0F, 1'b0, 1'b0, lat);
    chk("nocap_result", result_out, 8'hF0);
    chk("nocap_cap_cnt", n_cap - c_cap, 0);
    chk("nocap_latency", lat, 10);

    c_done = n_done;
    run_op(8'h5A, 1'b1, 1'b1, lat);
    step();
    chk("busy_done_cnt", n_done - c_done, 1);
    chk("busy_result", result_out, 8'h3C);

    c_upd = n_upd;
    start = 1'b1; pattern_in = 8'h33; capture_en = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    chk("rst_outputs", {WPSI0, wse_outputs, hold_outputs, capture_wr, update_wr, busy, done}, 0);
    chk("rst_result", result_out, 0);
    reset = 1'b0;
    step();
    chk("rst_upd_cnt", n_upd - c_upd, 0);
    run_op(8'hC3, 1'b1, 1'b0, lat);
    chk("rst_after_result", result_out, 8'h3C);
    chk("rst_after_latency", lat, 11);

    loopback = 1'b1;
    run_op(8'h96, 1'b1, 1'b0, lat);
    chk("loop_result", result_out, 8'h96);
    loopback = 1'b0;

`ifdef WBR_COMPARE_EN
    expected_in = 8'h3C; mask_in = 8'hFF;
    run_op(8'h11, 1'b1, 1'b0, lat);
    chk("cmp_equal", mismatch, 0);
    expected_in = 8'h3D; mask_in = 8'hFF;
    run_op(8'h22, 1'b1, 1'b0, lat);
    chk("cmp_diff", mismatch, 1);
    expected_in = 8'h3D; mask_in = 8'hFE;
    run_op(8'h44, 1'b1, 1'b0, lat);
    chk("cmp_masked", mismatch, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      capval = W'($urandom);
      if ($urandom_range(0, 1) == 1) load_chain(W'($urandom));
      loopback = ($urandom_range(0, 3) == 0);
`ifdef WBR_COMPARE_EN
      expected_in = ($urandom_range(0, 1) == 1) ? capval : W'($urandom);
      mask_in = W'($urandom);
`endif
      if ($urandom_range(0, 5) == 0) begin
        start = 1'b1; pattern_in = W'($urandom); capture_en = 1'($urandom);
        step();
        start = 1'b0;
        k = $urandom_range(0, 9);
        for (int i = 0; i < k; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
      end else begin
        run_op(W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), lat);
      end
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) step();
    end
    loopback = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
